// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- load/store unit control stage feeding the data memory port.
//
// Takes one memory op from EX and forms the word-aligned address, the byte
// mask and the lane-shifted store data. It strobes the memory port for one
// cycle, waits RD_LAT cycles for load data, then extracts and extends that
// data. It returns exactly one response per request to WB. Misaligned ops and
// illegal funct3 are answered with resp_err and never reach memory.
//
// Ports
//   clock, reset            clock; synchronous active-high reset
//   req_valid/req_ready     EX handshake (ready only while idle)
//   req_wen, req_funct3     1=store; RISC-V size/sign code
//   req_addr, req_wdata     byte address; right-aligned store data
//   mem_valid, mem_wen      one-cycle access strobe and write enable
//   mem_addr, mem_wdata     word address; lane-shifted store data
//   mem_wmask               byte mask (upper nibble always 0)
//   mem_rdata               raw read word, valid RD_LAT cycles after strobe
//   resp_valid/resp_ready   WB handshake
//   resp_rdata, resp_err    extended load data (0 for stores/errors); error flag
module lsu_ctrl #(
  parameter int RD_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state;
  logic        wen_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [2:0]  cnt;

  // Request decode, evaluated on the live request inputs at accept time.
  logic [1:0]  lane;
  logic        illegal, misaligned, req_err;
  logic [3:0]  st_mask;
  logic [31:0] st_data;

  always_comb begin
    lane    = req_addr[1:0];
    // 011, 110, 111 are not loads; stores have no unsigned forms.
    illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
              (req_wen && req_funct3[2]);
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    req_err = illegal || misaligned;
    case (req_funct3[1:0])
      2'b00:   st_mask = 4'b0001 << lane;
      2'b01:   st_mask = 4'b0011 << lane;
      default: st_mask = 4'b1111;
    endcase
    st_data = req_wdata << {lane, 3'b000};
  end

  // Load extract from the raw word using the latched lane and size.
  logic [31:0] rd_sh;
  logic [31:0] ld_data;

  always_comb begin
    rd_sh = mem_rdata >> {lane_q, 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{24{rd_sh[7]}}, rd_sh[7:0]};
      3'b001:  ld_data = {{16{rd_sh[15]}}, rd_sh[15:0]};
      3'b100:  ld_data = {24'h0, rd_sh[7:0]};
      3'b101:  ld_data = {16'h0, rd_sh[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      mem_valid  <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cnt        <= '0;
      wen_q      <= 1'b0;
      f3_q       <= '0;
      lane_q     <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          wen_q     <= req_wen;
          f3_q      <= req_funct3;
          lane_q    <= lane;
          req_ready <= 1'b0;
          if (req_err) begin
            // Bad ops skip memory entirely and answer on the next cycle.
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            state     <= ISSUE;
            mem_valid <= 1'b1;
            mem_wen   <= req_wen;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_wdata <= req_wen ? st_data : 32'h0;
            mem_wmask <= req_wen ? {4'h0, st_mask} : 8'h00;
          end
        end
        ISSUE: begin
          mem_valid <= 1'b0;
          mem_wen   <= 1'b0;
          mem_wmask <= '0;
          if (wen_q) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end else begin
            state <= WAIT;
            cnt   <= 3'(RD_LAT - 1);
          end
        end
        WAIT: begin
          // cnt==0 marks the cycle in which mem_rdata is valid.
          if (cnt == 3'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= ld_data;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: if (resp_ready) begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Two instances (RD_LAT=1 and RD_LAT=3) share stimulus; each is checked
// against a reference model computed from the load/store rules.
module tb_lsu_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, req_valid, req_wen, resp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, mem_rdata;

  logic [1:0]        req_ready, mem_valid, mem_wen, resp_valid, resp_err;
  logic [1:0][31:0]  mem_addr, mem_wdata, resp_rdata;
  logic [1:0][7:0]   mem_wmask;

  int n_chk  = 0;
  int n_pass = 0;

  lsu_ctrl #(.RD_LAT(1)) dut1 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_wen(req_wen), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid[0]), .mem_wen(mem_wen[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_wmask(mem_wmask[0]), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]));

  lsu_ctrl #(.RD_LAT(3)) dut3 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_wen(req_wen), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid[1]), .mem_wen(mem_wen[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_wmask(mem_wmask[1]), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]));

  function automatic int rd_lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Reference: size in bytes, legality, store lanes, load extension.
  function automatic void model(input logic wen, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, output logic err,
                                output logic [31:0] rdat, output logic [3:0] mask,
                                output logic [31:0] swd);
    int L, size;
    logic [31:0] v;
    L    = int'(a[1:0]);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    err  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (wen && f3 >= 3'd4) ||
           (size == 2 && (a % 2) != 0) || (size == 4 && (a % 4) != 0);
    mask = 4'h0; swd = 32'h0; rdat = 32'h0;
    if (!err && wen) begin
      mask = (size == 4) ? 4'hF : 4'(((1 << size) - 1) << L);
      swd  = wd << (8 * L);
    end
    if (!err && !wen) begin
      v = rd >> (8 * L);
      if (size == 1) begin
        v = v & 32'hFF;
        if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFFFF00;
      end else if (size == 2) begin
        v = v & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF0000;
      end
      rdat = v;
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; mem_rdata = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if ({req_ready[i], mem_valid[i], mem_wen[i], resp_valid[i], resp_err[i]} !== 5'b10000)
        $display("FAIL reset_ctl dut%0d got %b want 10000", i,
                 {req_ready[i], mem_valid[i], mem_wen[i], resp_valid[i], resp_err[i]});
      else n_pass++;
      n_chk++;
      if ({mem_addr[i], mem_wdata[i], mem_wmask[i], resp_rdata[i]} !== 104'h0)
        $display("FAIL reset_data dut%0d got %h want 0", i,
                 {mem_addr[i], mem_wdata[i], mem_wmask[i], resp_rdata[i]});
      else n_pass++;
    end
    reset = 1'b0;
  endtask

  // Issue one op with resp_ready=1 and check both instances cycle by cycle.
  task automatic run_op(input logic wen, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd);
    logic e; logic [31:0] xr, xw; logic [3:0] xm;
    int resp_at[2], pulses[2], extra[2], bad_idle[2], exp_lat;
    model(wen, f3, a, wd, rd, e, xr, xm, xw);
    @(negedge clock);
    req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = a; req_wdata = wd;
    mem_rdata = rd; resp_ready = 1'b1;
    n_chk++;
    if (req_ready !== 2'b11) $display("FAIL ready_idle got %b want 11", req_ready);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      resp_at[i] = -1; pulses[i] = 0; extra[i] = 0; bad_idle[i] = 0;
    end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (mem_valid[i]) begin
          pulses[i]++;
          n_chk++;
          if ({mem_wen[i], mem_addr[i], mem_wmask[i]} !== {wen, a[31:2], 2'b00, 4'h0, xm})
            $display("FAIL mem_ctl dut%0d a=%h got wen=%b addr=%h mask=%h want %b %h %h",
                     i, a, mem_wen[i], mem_addr[i], mem_wmask[i], wen,
                     {a[31:2], 2'b00}, {4'h0, xm});
          else n_pass++;
          if (wen) begin
            n_chk++;
            if (mem_wdata[i] !== xw)
              $display("FAIL mem_wdata dut%0d got %h want %h", i, mem_wdata[i], xw);
            else n_pass++;
          end
        end else if (mem_wen[i] || mem_wmask[i] != 8'h0) bad_idle[i]++;
        if (resp_valid[i]) begin
          if (resp_at[i] < 0) begin
            resp_at[i] = k;
            n_chk++;
            if ({resp_err[i], resp_rdata[i]} !== {e, xr})
              $display("FAIL resp dut%0d f3=%0d a=%h got err=%b rdata=%h want %b %h",
                       i, f3, a, resp_err[i], resp_rdata[i], e, xr);
            else n_pass++;
          end else extra[i]++;
        end
      end
      if (k < 12) @(negedge clock);
    end
    for (int i = 0; i < 2; i++) begin
      exp_lat = e ? 1 : wen ? 2 : 2 + rd_lat(i);
      n_chk++;
      if (resp_at[i] != exp_lat)
        $display("FAIL latency dut%0d f3=%0d wen=%b got %0d want %0d", i, f3, wen,
                 resp_at[i], exp_lat);
      else n_pass++;
      n_chk++;
      if (pulses[i] != (e ? 0 : 1))
        $display("FAIL strobes dut%0d got %0d want %0d", i, pulses[i], e ? 0 : 1);
      else n_pass++;
      n_chk++;
      if (extra[i] != 0 || bad_idle[i] != 0)
        $display("FAIL extra_activity dut%0d resp_extra=%0d idle_wen_mask=%0d want 0 0",
                 i, extra[i], bad_idle[i]);
      else n_pass++;
    end
  endtask

  task automatic test_directed();
    run_op(1'b0, 3'b010, 32'h80000004, 32'h0, 32'hDEADBEEF);  // lw
    run_op(1'b0, 3'b000, 32'h80000003, 32'h0, 32'h80FF1234);  // lb -> FFFFFF80
    run_op(1'b0, 3'b100, 32'h80000003, 32'h0, 32'h80FF1234);  // lbu -> 00000080
    run_op(1'b0, 3'b001, 32'h80000002, 32'h0, 32'h80FF1234);  // lh -> FFFF80FF
    run_op(1'b1, 3'b001, 32'h80000002, 32'h0000ABCD, 32'h0);  // sh
    run_op(1'b0, 3'b010, 32'h80000001, 32'h0, 32'h12345678);  // misaligned lw
    run_op(1'b0, 3'b011, 32'h80000000, 32'h0, 32'h12345678);  // illegal funct3
    run_op(1'b1, 3'b100, 32'h80000000, 32'h55, 32'h0);        // store with unsigned code
    run_op(1'b0, 3'b010, 32'hFFFFFFFF, 32'h0, 32'h1);         // wrap: misaligned
    run_op(1'b1, 3'b010, 32'hFFFFFFFC, 32'hCAFEF00D, 32'h0);  // sw at top word
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++)
      run_op(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
  endtask

  task automatic test_backpressure();
    logic e; logic [31:0] xr, xw, rd; logic [3:0] xm;
    int t;
    rd = $urandom;
    model(1'b0, 3'b001, 32'h80000006, 32'h0, rd, e, xr, xm, xw);
    @(negedge clock);
    req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b001; req_addr = 32'h80000006;
    mem_rdata = rd; resp_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    t = 0;
    while (resp_valid !== 2'b11 && t < 20) begin
      @(negedge clock);
      t++;
    end
    n_chk++;
    if (resp_valid !== 2'b11) $display("FAIL bp_timeout got %b want 11", resp_valid);
    else n_pass++;
    for (int c = 0; c < 5; c++) begin
      n_chk++;
      if (resp_valid !== 2'b11 || req_ready !== 2'b00 || resp_rdata[0] !== xr ||
          resp_rdata[1] !== xr)
        $display("FAIL bp_hold cyc%0d got v=%b rdy=%b d=%h/%h want 11 00 %h", c,
                 resp_valid, req_ready, resp_rdata[0], resp_rdata[1], xr);
      else n_pass++;
      @(negedge clock);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    n_chk++;
    if (resp_valid !== 2'b00 || req_ready !== 2'b11)
      $display("FAIL bp_release got v=%b rdy=%b want 00 11", resp_valid, req_ready);
    else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    int seen;
    @(negedge clock);
    req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80000010;
    mem_rdata = 32'h0BADF00D; resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);            // ISSUE
    req_valid = 1'b0;
    @(negedge clock);            // first WAIT cycle of both instances
    reset = 1'b1;
    @(negedge clock);
    n_chk++;
    if (resp_valid !== 2'b00 || mem_valid !== 2'b00 || req_ready !== 2'b11)
      $display("FAIL rst_wait got v=%b mv=%b rdy=%b want 00 00 11", resp_valid,
               mem_valid, req_ready);
    else n_pass++;
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (resp_valid != 2'b00 || mem_valid != 2'b00) seen++;
    end
    n_chk++;
    if (seen != 0) $display("FAIL rst_no_resp got %0d active cycles want 0", seen);
    else n_pass++;
    run_op(1'b1, 3'b010, 32'h80000020, 32'h13579BDF, 32'h0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
